// File: rtl/log_capture.sv
// Triggerable capture of one selected log channel into a dual-port RAM,
// with one-shot fill and circular pre/post-trigger modes plus decimation.
module log_capture #(
    parameter int NCH     = 4,
    parameter int IN_W    = 16,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 15,
    parameter int DECIM_W = 8
) (
    input  logic                  clockdsp,
    input  logic                  soft_reset,
    input  logic                  log_in_ram_run_from_micro,
    input  logic                  log_mode,
    input  logic [2:0]            log_input_select,
    input  logic                  log_signed,
    input  logic [DECIM_W-1:0]    log_decim,
    input  logic                  log_trigger,
    input  logic [ADDR_W-1:0]     log_posttrig_len,
    input  logic [NCH*IN_W-1:0]   log_in,
    input  logic                  log_in_valid,
    input  logic [ADDR_W-1:0]     log_read_addr_from_micro,
    output logic [DATA_W-1:0]     log_data_from_ram,
    output logic                  log_out_full_from_ram,
    output logic                  log_busy,
    output logic [ADDR_W-1:0]     log_trig_addr
);

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

    state_t                state_q, state_d;
    logic                  run_q, run_d;
    logic [NCH*IN_W-1:0]   in_q, in_d;
    logic                  valid_q, valid_d;
    logic                  trig_q, trig_d;
    logic [2:0]            sel_q, sel_d;
    logic                  sgn_q, sgn_d;
    logic [DECIM_W-1:0]    decim_q, decim_d;
    logic [DECIM_W-1:0]    dcnt_q, dcnt_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic [ADDR_W-1:0]     post_q, post_d;
    logic [ADDR_W-1:0]     trig_addr_q, trig_addr_d;
    logic                  full_q, full_d;
    logic                  busy_q, busy_d;
    logic                  active_s, we_s, run_rise_s;
    logic [IN_W-1:0]       chan_s;
    logic [DATA_W-1:0]     wdata_s;
    logic [DATA_W-1:0]     rd_q;
    logic [DATA_W-1:0]     mem [2**ADDR_W];

    // Next-state, write strobe and sample formatting
    always_comb begin
        state_d     = state_q;
        run_d       = log_in_ram_run_from_micro;
        in_d        = log_in;
        valid_d     = log_in_valid;
        trig_d      = log_trigger;
        sel_d       = sel_q;
        sgn_d       = sgn_q;
        decim_d     = decim_q;
        dcnt_d      = dcnt_q;
        waddr_d     = waddr_q;
        post_d      = post_q;
        trig_addr_d = trig_addr_q;

        run_rise_s = log_in_ram_run_from_micro & ~run_q;
        active_s   = (state_q == FILL) || (state_q == ARMED) || (state_q == POST);
        we_s       = active_s && valid_q && (dcnt_q == '0);

        // Unmatched selects (>= NCH) leave the sample at zero
        chan_s = '0;
        for (int k = 0; k < NCH; k++) begin
            chan_s = (sel_q == 3'(k)) ? in_q[k*IN_W +: IN_W] : chan_s;
        end
        wdata_s = sgn_q ? DATA_W'($signed(chan_s)) : DATA_W'(chan_s);

        if (active_s && valid_q) begin
            dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + DECIM_W'(1);
        end else begin
            dcnt_d = dcnt_q;
        end

        if (we_s) begin
            waddr_d = waddr_q + ADDR_W'(1);
        end else begin
            waddr_d = waddr_q;
        end

        case (state_q)
            IDLE, DONE: begin
                if (run_rise_s) begin
                    state_d = log_mode ? ARMED : FILL;
                    sel_d   = log_input_select;
                    sgn_d   = log_signed;
                    decim_d = log_decim;
                    dcnt_d  = '0;
                    waddr_d = '0;
                    post_d  = '0;
                end else begin
                    state_d = state_q;
                end
            end
            FILL: begin
                if (!log_in_ram_run_from_micro) begin
                    state_d = IDLE;
                end else if (we_s && (waddr_q == '1)) begin
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                end
            end
            ARMED: begin
                if (!log_in_ram_run_from_micro) begin
                    state_d = IDLE;
                end else if (we_s && trig_q) begin
                    trig_addr_d = waddr_q;
                    post_d      = '0;
                    state_d     = (log_posttrig_len == '0) ? DONE : POST;
                end else begin
                    state_d = ARMED;
                end
            end
            POST: begin
                if (!log_in_ram_run_from_micro) begin
                    state_d = IDLE;
                end else if (we_s) begin
                    post_d  = post_q + ADDR_W'(1);
                    state_d = ((post_q + ADDR_W'(1)) == log_posttrig_len) ? DONE : POST;
                end else begin
                    state_d = POST;
                end
            end
            default: state_d = IDLE;
        endcase

        full_d = (state_d == DONE);
        busy_d = (state_d == FILL) || (state_d == ARMED) || (state_d == POST);
    end

    // Control and input registers; run history is preset high so a run level
    // held across reset release is not mistaken for a fresh rising edge
    always_ff @(posedge clockdsp) begin
        if (soft_reset) begin
            state_q     <= IDLE;
            run_q       <= 1'b1;
            in_q        <= '0;
            valid_q     <= 1'b0;
            trig_q      <= 1'b0;
            sel_q       <= 3'd0;
            sgn_q       <= 1'b0;
            decim_q     <= '0;
            dcnt_q      <= '0;
            waddr_q     <= '0;
            post_q      <= '0;
            trig_addr_q <= '0;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            in_q        <= in_d;
            valid_q     <= valid_d;
            trig_q      <= trig_d;
            sel_q       <= sel_d;
            sgn_q       <= sgn_d;
            decim_q     <= decim_d;
            dcnt_q      <= dcnt_d;
            waddr_q     <= waddr_d;
            post_q      <= post_d;
            trig_addr_q <= trig_addr_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
        end
    end

    // Capture RAM: contents survive reset, read port is fully independent
    always_ff @(posedge clockdsp) begin
        if (we_s) begin
            mem[waddr_q] <= wdata_s;
        end
        rd_q <= mem[log_read_addr_from_micro];
    end

    assign log_data_from_ram     = rd_q;
    assign log_out_full_from_ram = full_q;
    assign log_busy              = busy_q;
    assign log_trig_addr         = trig_addr_q;

endmodule

// File: doc/log_capture.md
LOG_CAPTURE -- requirements
Module: log_capture

Interface
REQ-001 SHALL have parameter NCH, default 4, number of log input channels (1..8).
REQ-002 SHALL have parameter IN_W, default 16, width of each channel sample.
REQ-003 SHALL have parameter DATA_W, default 32, RAM word width (DATA_W >= IN_W).
REQ-004 SHALL have parameter ADDR_W, default 15, RAM address width; depth 2^ADDR_W.
REQ-005 SHALL have parameter DECIM_W, default 8, decimation control width.
REQ-006 clockdsp  in  1  sole clock; all logic rising-edge.
REQ-007 soft_reset  in  1  synchronous, active-high reset.
REQ-008 log_in_ram_run_from_micro  in  1  capture enable; rising edge starts, low aborts.
REQ-009 log_mode  in  1  0 = one-shot fill, 1 = circular pre/post-trigger.
REQ-010 log_input_select  in  3  channel written to RAM.
REQ-011 log_signed  in  1  1 = sign-extend sample, 0 = zero-extend.
REQ-012 log_decim  in  DECIM_W  store one of every log_decim+1 valid samples.
REQ-013 log_trigger  in  1  trigger event (mode 1 only).
REQ-014 log_posttrig_len  in  ADDR_W  samples stored after trigger sample.
REQ-015 log_in  in  NCH*IN_W  packed channels, channel k at bits [k*IN_W +: IN_W].
REQ-016 log_in_valid  in  1  qualifies log_in.
REQ-017 log_read_addr_from_micro  in  ADDR_W  read address.
REQ-018 log_data_from_ram  out  DATA_W  read data.
REQ-019 log_out_full_from_ram  out  1  capture complete, buffer readable.
REQ-020 log_busy  out  1  capture in progress.
REQ-021 log_trig_addr  out  ADDR_W  address holding the trigger sample.

Function
REQ-022 log_in and log_in_valid SHALL be registered once; the written sample is this registered copy of the selected channel, extended to DATA_W per log_signed.
REQ-023 log_input_select >= NCH SHALL write all-zero words.
REQ-024 FSM states SHALL be IDLE, FILL, ARMED, POST, DONE.
REQ-025 IDLE/DONE: run rising edge -> FILL (mode 0) or ARMED (mode 1); write address, decimation counter, full cleared that cycle.
REQ-026 Write strobe SHALL assert only in FILL/ARMED/POST when registered valid is high and decimation counter is 0; counter counts 0..log_decim on valid cycles, holds when valid low.
REQ-027 Write address SHALL increment by 1 per write, wrapping 2^ADDR_W-1 -> 0.
REQ-028 FILL: write at address 2^ADDR_W-1 -> DONE next cycle.
REQ-029 ARMED: registered log_trigger high on a write cycle -> that sample's address latched into log_trig_addr, go POST; triggers on non-write cycles ignored.
REQ-030 POST: count writes; after log_posttrig_len further writes -> DONE; log_posttrig_len=0 -> DONE the cycle after the trigger write; triggers ignored.
REQ-031 log_posttrig_len >= 2^ADDR_W SHALL be treated as 2^ADDR_W-1.
REQ-032 DONE: log_out_full_from_ram=1, no writes; held until reset or new run edge.
REQ-033 Run low in FILL/ARMED/POST -> IDLE next cycle, full stays 0, RAM contents undefined.
REQ-034 log_busy SHALL be 1 exactly in FILL, ARMED, POST.
REQ-035 log_mode, log_input_select, log_signed, log_decim SHALL be sampled at the run edge and held for the capture.
REQ-036 Read port SHALL be independent of write activity, 1-cycle latency; same-address collision returns old or new data (either accepted).

Reset
REQ-037 soft_reset SHALL force IDLE; full, busy, log_trig_addr, write address, counters, input registers to 0; reset mid-capture aborts identically.
REQ-038 RAM contents SHALL NOT be cleared by reset.
REQ-039 Run held high through reset release SHALL NOT start a capture; a new rising edge is needed.

Verification (ADDR_W=4, NCH=4, IN_W=16, DATA_W=32)
REQ-040 Mode 0, decim 0, ch 1 = ramp 0..15 with valid=1, run edge -> full after 16 writes; addr n reads n.
REQ-041 Mode 0, decim 2, signed, ch 2 = 16'h8000 -> every 3rd valid sample stored, read 32'hFFFF8000; valid gaps stretch capture accordingly.
REQ-042 Mode 1, posttrig 5, ramp input, trigger on value 20 -> trig_addr = 20 mod 16 = 4; last written value 25 at addr 9; full=1.
REQ-043 Mode 1, posttrig 0 -> DONE one cycle after trigger write; trigger pulse on decimated-out cycle ignored.
REQ-044 Run dropped mid-FILL and soft_reset mid-POST -> IDLE, full 0, busy 0; new run edge restarts at addr 0.
REQ-045 log_input_select = 5 -> stored words all 32'h0.
